// File: rtl/audio_pkg.sv
// Audio types shared by the sample sources and the I2S transmitter.
package audio_pkg;

  localparam int SAMPLE_W = 16;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/i2s_tx_if.sv
// Sample handshake between an upstream audio source and the I2S transmitter.
interface i2s_tx_if;
  import audio_pkg::*;

  stereo_sample_t sample;
  logic           mute;
  logic           sample_req;

  modport master (output sample, output mute, input sample_req);
  modport slave  (input sample, input mute, output sample_req);

endinterface

// File: rtl/i2s_clk_gen.sv
// Bit-clock divider: owns div_cnt and bclk, and flags the cycle whose edge drives bclk low.
module i2s_clk_gen #(
  parameter int BCLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic bclk,
  output logic fall_evt
);

  localparam int               CNT_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BCLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt_reg;
  logic             bclk_reg;
  logic             toggle;

  assign toggle = (div_cnt_reg == CNT_LAST);
  // Decoded from registered state so the consumer updates on the same edge as bclk falls.
  assign fall_evt = toggle & bclk_reg;
  assign bclk     = bclk_reg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_cnt_reg <= '0;
      bclk_reg    <= 1'b0;
    end else begin
      div_cnt_reg <= toggle ? '0 : div_cnt_reg + 1'b1;
      if (toggle) begin
        bclk_reg <= ~bclk_reg;
      end
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: generates BCLK/LRCLK, requests one stereo sample per frame
// and shifts it out MSB-first with the one-BCLK data delay after each word-select edge.
module i2s_tx
  import audio_pkg::*;
#(
  parameter int BCLK_DIV  = 4,
  parameter int SLOT_BITS = 32
) (
  input  logic    i_clk,
  input  logic    i_rst,
  i2s_tx_if.slave tx,
  output logic    o_bclk,
  output logic    o_lrclk,
  output logic    o_sd
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] RIGHT_SLOT = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] LOAD_BIT   = BIT_W'(1);

  logic                  fall_evt;
  logic                  bclk;
  stereo_sample_t        smp;
  logic [FRAME_BITS-1:0] load_word;

  logic [BIT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic [FRAME_BITS-1:0] word_reg, word_next;
  logic                  lrclk_reg, lrclk_next;
  logic                  sd_reg, sd_next;
  logic                  req_reg, req_next;

  i2s_clk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_clk_gen (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .bclk     (bclk),
    .fall_evt (fall_evt)
  );

  assign smp = tx.sample;

  // Each channel is left-justified in its slot, padded with zeros below the LSB.
  always_comb begin
    load_word = '0;
    if (!tx.mute) begin
      load_word[FRAME_BITS-1 -: SAMPLE_W] = smp.left;
      load_word[SLOT_BITS-1  -: SAMPLE_W] = smp.right;
    end
  end

  always_comb begin
    bit_cnt_next = bit_cnt_reg;
    word_next    = word_reg;
    lrclk_next   = lrclk_reg;
    sd_next      = sd_reg;
    req_next     = 1'b0;
    if (fall_evt) begin
      bit_cnt_next = (bit_cnt_reg == BIT_LAST) ? '0 : bit_cnt_reg + 1'b1;
      lrclk_next   = (bit_cnt_next >= RIGHT_SLOT);
      req_next     = (bit_cnt_next == '0);
      // Bit 1 loads the new frame and drives its MSB in the same edge.
      if (bit_cnt_next == LOAD_BIT) begin
        sd_next   = load_word[FRAME_BITS-1];
        word_next = {load_word[FRAME_BITS-2:0], 1'b0};
      end else begin
        sd_next   = word_reg[FRAME_BITS-1];
        word_next = {word_reg[FRAME_BITS-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bit_cnt_reg <= BIT_LAST;
      word_reg    <= '0;
      lrclk_reg   <= 1'b1;
      sd_reg      <= 1'b0;
      req_reg     <= 1'b0;
    end else begin
      bit_cnt_reg <= bit_cnt_next;
      word_reg    <= word_next;
      lrclk_reg   <= lrclk_next;
      sd_reg      <= sd_next;
      req_reg     <= req_next;
    end
  end

  assign o_bclk        = bclk;
  assign o_lrclk       = lrclk_reg;
  assign o_sd          = sd_reg;
  assign tx.sample_req = req_reg;

endmodule
